// File: rtl/rom_fetch_pkg.sv
// Shared definitions for the ROM fetch controller: FSM encoding and counter sizing.
package rom_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

    // Wait counter width: max(1, clog2(wait_cycles+1)).
    function automatic int unsigned ctr_width(input int unsigned wait_cycles);
        int unsigned w;
        w = $clog2(wait_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rom_fetch_waitctr.sv
// Loadable down-counter with a zero flag; times the ROM access window.
module rom_fetch_waitctr #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero_c
);

    logic [WIDTH-1:0] r_count;

    // Load takes priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/rom_fetch.sv
// Synchronous read controller for an asynchronous ROM with programmable wait states.
// Optional burst reads are enabled by defining ROM_FETCH_BURST_EN.
module rom_fetch
    import rom_fetch_pkg::*;
#(
    parameter int unsigned AWIDTH      = 8,
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              req,
    input  logic [AWIDTH-1:0] addr,
    output logic              ack,
    output logic [DWIDTH-1:0] data_out,
    output logic              busy,
    output logic [AWIDTH-1:0] rom_a,
    output logic              rom_nce,
    output logic              rom_noe,
    input  logic [DWIDTH-1:0] rom_d
);

    localparam int unsigned CW = ctr_width(WAIT_CYCLES);
    localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES);

    state_e r_state;
    state_e w_state_nxt;
    logic   w_ctr_zero;
    logic   w_last;
    logic   w_burst;
    logic   w_accept;
    logic   w_ctr_load;
    logic   w_ctr_dec;
    logic   w_nce_nxt;
    logic   w_noe_nxt;
    logic   w_busy_nxt;

    rom_fetch_waitctr #(
        .WIDTH (CW)
    ) u_waitctr (
        .clk        (clk),
        .nreset     (nreset),
        .i_load     (w_ctr_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (w_ctr_dec),
        .o_zero_c   (w_ctr_zero)
    );

    // Final ACCESS cycle detection and burst continuation.
    always_comb begin
        w_accept = (r_state == ST_IDLE) && req;
        w_last   = (r_state == ST_ACCESS) && w_ctr_zero;
`ifdef ROM_FETCH_BURST_EN
        w_burst  = w_last && req;
`else
        w_burst  = 1'b0;
`endif
        w_ctr_load = (r_state == ST_SETUP) || w_burst;
        w_ctr_dec  = (r_state == ST_ACCESS) && !w_last;
    end

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (req) w_state_nxt = ST_SETUP;
            ST_SETUP:   w_state_nxt = ST_ACCESS;
            ST_ACCESS:  if (w_last) w_state_nxt = w_burst ? ST_ACCESS : ST_RECOVER;
            ST_RECOVER: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobe values for the upcoming state; registered below so outputs never glitch.
    always_comb begin
        w_nce_nxt  = 1'b1;
        w_noe_nxt  = 1'b1;
        w_busy_nxt = 1'b1;
        case (w_state_nxt)
            ST_IDLE:   w_busy_nxt = 1'b0;
            ST_SETUP:  w_nce_nxt  = 1'b0;
            ST_ACCESS: begin
                w_nce_nxt = 1'b0;
                w_noe_nxt = 1'b0;
            end
            default:   ;
        endcase
    end

    // Registered strobes, address and data path.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rom_nce  <= 1'b1;
            rom_noe  <= 1'b1;
            busy     <= 1'b0;
            ack      <= 1'b0;
            rom_a    <= '0;
            data_out <= '0;
        end else begin
            rom_nce <= w_nce_nxt;
            rom_noe <= w_noe_nxt;
            busy    <= w_busy_nxt;
            ack     <= w_last;
            if (w_accept) begin
                rom_a <= addr;
            end else if (w_burst) begin
                rom_a <= rom_a + AWIDTH'(1);
            end
            if (w_last) begin
                data_out <= rom_d;
            end
        end
    end

endmodule

// File: tb/tb_rom_fetch.sv
// Directed bench for rom_fetch with a 70 ns asynchronous ROM model (mem[i] = i ^ 0xF0).
// Burst expectations follow ROM_FETCH_BURST_EN when it is defined.
module tb_rom_fetch;

    logic       clk;
    logic       clk2;
    logic       nreset;
    logic       req;
    logic [7:0] addr;
    logic       ack;
    logic [7:0] data_out;
    logic       busy;
    logic [7:0] rom_a;
    logic       rom_nce;
    logic       rom_noe;
    logic [7:0] rom_d;

    logic       req0;
    logic [7:0] addr0;
    logic       ack0;
    logic [7:0] data_out0;
    logic       busy0;
    logic [7:0] rom_a0;
    logic       rom_nce0;
    logic       rom_noe0;
    logic [7:0] rom_d0;

    logic [7:0] mem [256];

    int checks;
    int errors;

    rom_fetch #(.AWIDTH(8), .DWIDTH(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .nreset(nreset), .req(req), .addr(addr), .ack(ack),
        .data_out(data_out), .busy(busy), .rom_a(rom_a), .rom_nce(rom_nce),
        .rom_noe(rom_noe), .rom_d(rom_d)
    );

    rom_fetch #(.AWIDTH(8), .DWIDTH(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk2), .nreset(nreset), .req(req0), .addr(addr0), .ack(ack0),
        .data_out(data_out0), .busy(busy0), .rom_a(rom_a0), .rom_nce(rom_nce0),
        .rom_noe(rom_noe0), .rom_d(rom_d0)
    );

    // 70 ns access-time ROMs
    assign #70 rom_d  = (!rom_nce  && !rom_noe)  ? mem[rom_a]  : 8'hzz;
    assign #70 rom_d0 = (!rom_nce0 && !rom_noe0) ? mem[rom_a0] : 8'hzz;

    // 20 MHz main clock, 10 MHz clock offset so its edges never coincide with clk
    initial begin
        clk = 1'b0;
        forever #25 clk = ~clk;
    end

    initial begin
        clk2 = 1'b0;
        #10;
        forever #50 clk2 = ~clk2;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic test_reset();
        #10 nreset = 1'b0;
        #1;
        checks++; if (rom_nce !== 1'b1) begin errors++; $display("FAIL reset_async_nce: got %b expected 1", rom_nce); end
        checks++; if (rom_noe !== 1'b1) begin errors++; $display("FAIL reset_async_noe: got %b expected 1", rom_noe); end
        checks++; if (rom_a !== 8'h00) begin errors++; $display("FAIL reset_async_rom_a: got %h expected 00", rom_a); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_async_data: got %h expected 00", data_out); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_async_ack: got %b expected 0", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_async_busy: got %b expected 0", busy); end
        addr = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req = ~req;
        end
        @(negedge clk);
        checks++; if (rom_nce !== 1'b1 || rom_noe !== 1'b1 || busy !== 1'b0 || ack !== 1'b0 || rom_a !== 8'h00)
            begin errors++; $display("FAIL reset_held: got nce=%b noe=%b busy=%b ack=%b a=%h expected 1 1 0 0 00", rom_nce, rom_noe, busy, ack, rom_a); end
        req = 1'b0;
        nreset = 1'b1;
    endtask

    task automatic test_single_read();
        logic e_nce, e_noe, e_ack, e_busy;
        @(negedge clk);
        req = 1'b1;
        addr = 8'h12;
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) begin req = 1'b0; addr = 8'h55; end
            e_nce  = !(c <= 4);
            e_noe  = !(c >= 2 && c <= 4);
            e_ack  = (c == 5);
            e_busy = (c <= 5);
            checks++; if (rom_nce !== e_nce) begin errors++; $display("FAIL single_nce c%0d: got %b expected %b", c, rom_nce, e_nce); end
            checks++; if (rom_noe !== e_noe) begin errors++; $display("FAIL single_noe c%0d: got %b expected %b", c, rom_noe, e_noe); end
            checks++; if (ack !== e_ack) begin errors++; $display("FAIL single_ack c%0d: got %b expected %b", c, ack, e_ack); end
            checks++; if (busy !== e_busy) begin errors++; $display("FAIL single_busy c%0d: got %b expected %b", c, busy, e_busy); end
            if (c == 3) begin
                checks++; if (rom_a !== 8'h12) begin errors++; $display("FAIL single_rom_a: got %h expected 12", rom_a); end
                checks++; if (rom_d !== 8'hE2) begin errors++; $display("FAIL single_rom_d_early: got %h expected e2", rom_d); end
            end
            if (c == 5) begin
                checks++; if (data_out !== 8'hE2) begin errors++; $display("FAIL single_data: got %h expected e2", data_out); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int         n;
        int         cyc [4];
        logic [7:0] dat [4];
        n = 0;
        @(negedge clk);
        req = 1'b1;
        addr = 8'h00;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) addr = 8'hFF;
            if (c == 7) req = 1'b0;
            if (ack === 1'b1 && n < 4) begin cyc[n] = c; dat[n] = data_out; n++; end
            if (c == 5 || c == 6) begin
                checks++; if (rom_nce !== 1'b1) begin errors++; $display("FAIL b2b_nce_gap c%0d: got %b expected 1", c, rom_nce); end
            end
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_ack_count: got %0d expected 2", n); end
        if (n >= 2) begin
            checks++; if (cyc[0] !== 5 || cyc[1] !== 11) begin errors++; $display("FAIL b2b_ack_cycles: got %0d,%0d expected 5,11", cyc[0], cyc[1]); end
            checks++; if (dat[0] !== 8'hF0) begin errors++; $display("FAIL b2b_data0: got %h expected f0", dat[0]); end
            checks++; if (dat[1] !== 8'h0F) begin errors++; $display("FAIL b2b_data1: got %h expected 0f", dat[1]); end
        end
    endtask

    task automatic test_reset_mid_read();
        logic saw_ack;
        saw_ack = 1'b0;
        @(negedge clk);
        req = 1'b1;
        addr = 8'h34;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #5 nreset = 1'b0;
        #1;
        checks++; if (rom_nce !== 1'b1 || rom_noe !== 1'b1) begin errors++; $display("FAIL midrst_strobes: got nce=%b noe=%b expected 1 1", rom_nce, rom_noe); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", data_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ack !== 1'b0) saw_ack = 1'b1;
        end
        nreset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ack !== 1'b0) saw_ack = 1'b1;
        end
        checks++; if (saw_ack !== 1'b0) begin errors++; $display("FAIL midrst_no_ack: got %b expected 0", saw_ack); end
        req = 1'b1;
        addr = 8'h34;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) req = 1'b0;
            if (c == 4) begin
                checks++; if (ack !== 1'b0) begin errors++; $display("FAIL midrst_reread_ack_early: got %b expected 0", ack); end
            end
            if (c == 5) begin
                checks++; if (ack !== 1'b1) begin errors++; $display("FAIL midrst_reread_ack: got %b expected 1", ack); end
                checks++; if (data_out !== 8'hC4) begin errors++; $display("FAIL midrst_reread_data: got %h expected c4", data_out); end
            end
        end
    endtask

    task automatic test_burst();
        int         n;
        int         cyc [4];
        logic [7:0] dat [4];
        int         e_cyc [3];
        logic [7:0] e_dat [3];
        int         rel;
        logic       nce_rose;
        n = 0;
        nce_rose = 1'b0;
`ifdef ROM_FETCH_BURST_EN
        e_cyc[0] = 5; e_cyc[1] = 8;  e_cyc[2] = 11;
        e_dat[0] = 8'h0E; e_dat[1] = 8'h0F; e_dat[2] = 8'hF0;
        rel = 8;
`else
        e_cyc[0] = 5; e_cyc[1] = 11; e_cyc[2] = 17;
        e_dat[0] = 8'h0E; e_dat[1] = 8'h0E; e_dat[2] = 8'h0E;
        rel = 13;
`endif
        @(negedge clk);
        req = 1'b1;
        addr = 8'hFE;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ack === 1'b1 && n < 4) begin cyc[n] = c; dat[n] = data_out; n++; end
            if (c == rel) req = 1'b0;
`ifdef ROM_FETCH_BURST_EN
            if (c <= 10 && rom_nce !== 1'b0) nce_rose = 1'b1;
            if (c == 6) begin
                checks++; if (rom_a !== 8'hFF) begin errors++; $display("FAIL burst_rom_a_ff: got %h expected ff", rom_a); end
            end
            if (c == 9) begin
                checks++; if (rom_a !== 8'h00) begin errors++; $display("FAIL burst_rom_a_wrap: got %h expected 00", rom_a); end
            end
            if (c == 11) begin
                checks++; if (rom_nce !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL burst_recover: got nce=%b busy=%b expected 1 1", rom_nce, busy); end
            end
            if (c == 12) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_idle: got busy=%b expected 0", busy); end
            end
`else
            if (c == 6 || c == 12) begin
                checks++; if (rom_nce !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL burst_off_idle c%0d: got nce=%b busy=%b expected 1 0", c, rom_nce, busy); end
            end
`endif
        end
`ifdef ROM_FETCH_BURST_EN
        checks++; if (nce_rose !== 1'b0) begin errors++; $display("FAIL burst_nce_held: got %b expected 0", nce_rose); end
`endif
        checks++; if (n !== 3) begin errors++; $display("FAIL burst_ack_count: got %0d expected 3", n); end
        if (n >= 3) begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (cyc[k] !== e_cyc[k]) begin errors++; $display("FAIL burst_ack_cycle%0d: got %0d expected %0d", k, cyc[k], e_cyc[k]); end
                checks++; if (dat[k] !== e_dat[k]) begin errors++; $display("FAIL burst_data%0d: got %h expected %h", k, dat[k], e_dat[k]); end
            end
        end
    endtask

    task automatic test_wait0();
        logic e_nce, e_noe, e_ack, e_busy;
        @(negedge clk2);
        req0 = 1'b1;
        addr0 = 8'h80;
        @(posedge clk2);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk2);
            if (c == 1) req0 = 1'b0;
            e_nce  = !(c <= 2);
            e_noe  = !(c == 2);
            e_ack  = (c == 3);
            e_busy = (c <= 3);
            checks++; if (rom_nce0 !== e_nce || rom_noe0 !== e_noe) begin errors++; $display("FAIL w0_strobes c%0d: got nce=%b noe=%b expected %b %b", c, rom_nce0, rom_noe0, e_nce, e_noe); end
            checks++; if (ack0 !== e_ack || busy0 !== e_busy) begin errors++; $display("FAIL w0_ack_busy c%0d: got ack=%b busy=%b expected %b %b", c, ack0, busy0, e_ack, e_busy); end
            if (c == 3) begin
                checks++; if (data_out0 !== 8'h70) begin errors++; $display("FAIL w0_data: got %h expected 70", data_out0); end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hF0;
        nreset = 1'b1;
        req    = 1'b0;
        addr   = 8'h00;
        req0   = 1'b0;
        addr0  = 8'h00;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_reset_mid_read();
        test_burst();
        test_wait0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
